// File: rtl/pit_multi_pkg.sv
// rtl/pit_multi_pkg.sv - shared encodings and helpers for the multi-channel interval timer
package pit_multi_pkg;

   localparam logic [2:0] MODE_0 = 3'd0;
   localparam logic [2:0] MODE_2 = 3'd2;
   localparam logic [2:0] MODE_3 = 3'd3;

   localparam logic [1:0] ACC_LATCH = 2'b00;
   localparam logic [1:0] ACC_LSB   = 2'b01;
   localparam logic [1:0] ACC_MSB   = 2'b10;
   localparam logic [1:0] ACC_WORD  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_RUN
   } ch_state_t;

   // Unsupported modes fold onto the nearest supported one.
   function automatic logic [2:0] map_mode(input logic [2:0] m);
      case (m)
         3'd2, 3'd6: map_mode = MODE_2;
         3'd3, 3'd7: map_mode = MODE_3;
         default:    map_mode = MODE_0;
      endcase
   endfunction

endpackage

// File: rtl/pit_multi_channel.sv
// rtl/pit_multi_channel.sv - one timer channel: control, count, latch and mode sequencing
module pit_multi_channel
   import pit_multi_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick,
   input  logic       gate,
   input  logic       wr_ctrl,
   input  logic       wr_data,
   input  logic       rd,
   input  logic [7:0] wdata,
   output logic [7:0] rdata,
   output logic       out
);
   typedef logic [CNT_W-1:0] cnt_t;

   ch_state_t  state;
   logic [2:0] mode;
   logic [1:0] access;
   cnt_t       count;
   cnt_t       init;
   cnt_t       latch_val;
   logic [7:0] lsb_hold;
   logic       wr_msb;
   logic       rd_msb;
   logic       latch_pend;
   logic       hold;
   logic       rearm;

   logic [15:0] rd_val;
   logic [15:0] wr_word;
   cnt_t        sq_reload;
   logic        sq_odd;
   logic        wr_done;

   always_comb begin
      rd_val = 16'(latch_pend ? latch_val : count);
      if (access == ACC_MSB || (access == ACC_WORD && rd_msb))
         rdata = rd_val[15:8];
      else
         rdata = rd_val[7:0];
      // Square wave counts by two; N=1 behaves as the full 2^CNT_W range.
      sq_reload = (init == cnt_t'(1)) ? '0 : {init[CNT_W-1:1], 1'b0};
      sq_odd    = init[0] && (init != cnt_t'(1));
      case (access)
         ACC_LSB: wr_word = {8'h00, wdata};
         ACC_MSB: wr_word = {wdata, 8'h00};
         default: wr_word = {wdata, lsb_hold};
      endcase
      wr_done = wr_data && (access != ACC_WORD || wr_msb);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         mode       <= MODE_0;
         access     <= ACC_WORD;
         count      <= '0;
         init       <= '0;
         latch_val  <= '0;
         lsb_hold   <= 8'h00;
         wr_msb     <= 1'b0;
         rd_msb     <= 1'b0;
         latch_pend <= 1'b0;
         hold       <= 1'b0;
         rearm      <= 1'b0;
         out        <= 1'b1;
      end else if (wr_ctrl && wdata[5:4] != ACC_LATCH) begin
         mode       <= map_mode(wdata[3:1]);
         access     <= wdata[5:4];
         state      <= ST_IDLE;
         wr_msb     <= 1'b0;
         rd_msb     <= 1'b0;
         latch_pend <= 1'b0;
         hold       <= 1'b0;
         rearm      <= 1'b0;
         out        <= (map_mode(wdata[3:1]) != MODE_0);
      end else begin
         if (wr_ctrl && !latch_pend) begin
            latch_val  <= count;
            latch_pend <= 1'b1;
         end
         if (rd) begin
            if (access == ACC_WORD)
               rd_msb <= !rd_msb;
            if (access != ACC_WORD || rd_msb)
               latch_pend <= 1'b0;
         end

         if (tick && state == ST_LOAD) begin
            count <= (mode == MODE_3) ? sq_reload : init;
            hold  <= (mode == MODE_3) && sq_odd;
            rearm <= 1'b0;
            state <= ST_RUN;
            if (mode != MODE_0)
               out <= 1'b1;
         end else if (tick && state == ST_RUN && gate) begin
            case (mode)
               MODE_2: begin
                  if (rearm || count == cnt_t'(1)) begin
                     count <= init;
                     out   <= 1'b1;
                     rearm <= 1'b0;
                  end else begin
                     count <= count - cnt_t'(1);
                     out   <= (count != cnt_t'(2));
                  end
               end
               MODE_3: begin
                  if (rearm) begin
                     count <= sq_reload;
                     out   <= 1'b1;
                     hold  <= sq_odd;
                     rearm <= 1'b0;
                  end else if (hold) begin
                     hold <= 1'b0;
                  end else if (count == cnt_t'(2)) begin
                     count <= sq_reload;
                     out   <= !out;
                     hold  <= !out && sq_odd;
                  end else begin
                     count <= count - cnt_t'(2);
                  end
               end
               default: begin
                  count <= count - cnt_t'(1);
                  if (count == cnt_t'(1))
                     out <= 1'b1;
               end
            endcase
         end

         // Gate low parks the periodic modes high and forces a reload on resume.
         if (state == ST_RUN && mode != MODE_0 && !gate) begin
            out   <= 1'b1;
            rearm <= 1'b1;
         end

         if (wr_data && access == ACC_WORD && !wr_msb) begin
            lsb_hold <= wdata;
            wr_msb   <= 1'b1;
         end
         if (wr_done) begin
            init   <= cnt_t'(wr_word);
            wr_msb <= 1'b0;
            state  <= ST_LOAD;
            if (mode == MODE_0)
               out <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/pit_multi.sv
// rtl/pit_multi.sv - multi-channel interval timer: tick accumulator, io decode and read path
module pit_multi
   import pit_multi_pkg::*;
#(
   parameter int NUM_CH  = 3,
   parameter int CNT_W   = 16,
   parameter int TICK_HZ = 1193182,
   parameter int RATE_W  = 28
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [RATE_W-1:0] clock_rate,
   input  logic [2:0]        io_address,
   input  logic              io_read,
   output logic [7:0]        io_readdata,
   input  logic              io_write,
   input  logic [7:0]        io_writedata,
   input  logic [NUM_CH-1:0] gate,
   output logic [NUM_CH-1:0] out,
   output logic [NUM_CH-1:0] out_rise
);
   typedef logic [RATE_W:0] acc_ext_t;
   localparam acc_ext_t TICK_EXT = acc_ext_t'(TICK_HZ);

   logic [RATE_W-1:0] rate_q;
   logic [RATE_W-1:0] acc;
   acc_ext_t          acc_sum;
   logic              tick;
   logic              rd_prev;
   logic              rd_valid;
   logic [NUM_CH-1:0] out_q;
   logic [7:0]        ch_rdata [NUM_CH];
   logic [7:0]        rd_byte;

   assign acc_sum  = {1'b0, acc} + TICK_EXT;
   assign rd_valid = io_read && !rd_prev;
   assign out_rise = out & ~out_q;

   // A clock no faster than the tick rate cannot produce a fractional tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rate_q <= '0;
         acc    <= '0;
         tick   <= 1'b0;
      end else begin
         rate_q <= clock_rate;
         tick   <= 1'b0;
         if ({1'b0, rate_q} <= TICK_EXT) begin
            acc <= '0;
         end else if (acc_sum >= {1'b0, rate_q}) begin
            acc  <= RATE_W'(acc_sum - {1'b0, rate_q});
            tick <= 1'b1;
         end else begin
            acc <= acc_sum[RATE_W-1:0];
         end
      end
   end

   always_comb begin
      rd_byte = 8'h00;
      for (int i = 0; i < NUM_CH; i++)
         if (io_address == 3'(i))
            rd_byte = ch_rdata[i];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_prev     <= 1'b0;
         io_readdata <= 8'h00;
         out_q       <= '1;
      end else begin
         rd_prev     <= rd_valid;
         io_readdata <= rd_valid ? rd_byte : 8'h00;
         out_q       <= out;
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      pit_multi_channel #(
         .CNT_W(CNT_W)
      ) u_ch (
         .clk    (clk),
         .rst_n  (rst_n),
         .tick   (tick),
         .gate   (gate[i]),
         .wr_ctrl(io_write && io_address == 3'(i + 4)),
         .wr_data(io_write && io_address == 3'(i)),
         .rd     (rd_valid && io_address == 3'(i)),
         .wdata  (io_writedata),
         .rdata  (ch_rdata[i]),
         .out    (out[i])
      );
   end

endmodule

// File: tb/tb_pit_multi.sv
// tb/tb_pit_multi.sv - directed self-checking bench for pit_multi
module tb_pit_multi;
   localparam int TICK_HZ = 1193182;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [27:0] clock_rate = '0;
   logic [2:0]  io_address = '0;
   logic        io_read = 1'b0;
   logic        io_write = 1'b0;
   logic [7:0]  io_writedata = '0;
   logic [7:0]  io_readdata;
   logic [7:0]  io_readdata2;
   logic [2:0]  gate = 3'b111;
   logic [2:0]  out;
   logic [2:0]  out_rise;
   logic [1:0]  out2;
   logic [1:0]  out_rise2;

   int checks = 0;
   int failures = 0;
   int rise0_cnt = 0;

   always #5 clk = ~clk;

   always @(negedge clk)
      if (out_rise[0])
         rise0_cnt++;

   pit_multi #(.NUM_CH(3), .CNT_W(16), .TICK_HZ(TICK_HZ), .RATE_W(28)) dut (
      .clk(clk), .rst_n(rst_n), .clock_rate(clock_rate),
      .io_address(io_address), .io_read(io_read), .io_readdata(io_readdata),
      .io_write(io_write), .io_writedata(io_writedata),
      .gate(gate), .out(out), .out_rise(out_rise)
   );

   pit_multi #(.NUM_CH(2), .CNT_W(16), .TICK_HZ(TICK_HZ), .RATE_W(28)) dut2 (
      .clk(clk), .rst_n(rst_n), .clock_rate(clock_rate),
      .io_address(io_address), .io_read(io_read), .io_readdata(io_readdata2),
      .io_write(io_write), .io_writedata(io_writedata),
      .gate(gate[1:0]), .out(out2), .out_rise(out_rise2)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic io_wr(input logic [2:0] a, input logic [7:0] d);
      @(negedge clk);
      io_address = a; io_writedata = d; io_write = 1'b1;
      @(posedge clk); #1;
      io_write = 1'b0;
   endtask

   task automatic io_rd(input logic [2:0] a, output logic [7:0] d, output logic [7:0] d2);
      @(negedge clk);
      io_address = a; io_read = 1'b1;
      @(posedge clk); #1;
      io_read = 1'b0;
      d = io_readdata; d2 = io_readdata2;
      @(posedge clk); #1;
   endtask

   task automatic io_rd2(input logic [2:0] a, output logic [7:0] d);
      @(negedge clk);
      io_address = a; io_read = 1'b1;
      @(posedge clk); #1;
      d = io_readdata;
      @(posedge clk); #1;
      io_read = 1'b0;
      check("rd2_second_cycle", io_readdata, 0);
   endtask

   task automatic wait_tick();
      int n = 0;
      @(negedge clk);
      while (!dut.tick && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) check("tick_timeout", 0, 1);
      @(posedge clk); #1;
   endtask

   task automatic tick_pattern(input string tag, input int ch, input int n, input logic [15:0] pat);
      for (int i = 0; i < n; i++) begin
         wait_tick();
         check($sformatf("%s%0d", tag, i + 1), out[ch], pat[n-1-i]);
      end
   endtask

   initial begin
      logic [7:0] d;
      logic [7:0] d2;
      int rise_base;
      int tick_cnt;

      clock_rate = 28'(TICK_HZ * 4);
      repeat (3) @(negedge clk);
      check("rst_readdata", io_readdata, 0);
      check("rst_out", out, 3'b111);
      check("rst_out2", out2, 2'b11);
      check("rst_rise", out_rise, 0);
      rst_n = 1'b1;

      for (int k = 1; k <= 12; k++) begin
         @(posedge clk); #1;
         check($sformatf("tick_k%0d", k), dut.tick, (k >= 5 && (k - 5) % 4 == 0));
      end
      check("rise_after_rst", out_rise, 0);

      io_wr(3'd4, 8'h30);
      check("m0_ctrl_out", out[0], 0);
      io_wr(3'd0, 8'h05);
      io_wr(3'd0, 8'h00);
      check("m0_wr_out", out[0], 0);
      rise_base = rise0_cnt;
      tick_pattern("m0_t", 0, 6, 16'b000001);
      check("m0_rise_pulse", out_rise[0], 1);
      repeat (10) wait_tick();
      check("m0_hold_high", out[0], 1);
      check("m0_rise_count", rise0_cnt - rise_base, 1);

      io_wr(3'd5, 8'h34);
      io_wr(3'd1, 8'h04);
      io_wr(3'd1, 8'h00);
      tick_pattern("m2_t", 1, 8, 16'b11101110);
      gate[1] = 1'b0;
      @(posedge clk); #1;
      check("m2_gate_low_out", out[1], 1);
      io_rd(3'd1, d, d2);
      check("m2_held_lsb", d, 8'h01);
      io_rd(3'd1, d, d2);
      check("m2_held_msb", d, 8'h00);
      wait_tick();
      wait_tick();
      check("m2_gate_low_still", out[1], 1);
      gate[1] = 1'b1;
      tick_pattern("m2_g", 1, 4, 16'b1110);

      io_wr(3'd6, 8'h36);
      io_wr(3'd2, 8'h05);
      io_wr(3'd2, 8'h00);
      tick_pattern("m3o_t", 2, 10, 16'b1110011100);
      io_wr(3'd6, 8'h36);
      io_wr(3'd2, 8'h04);
      io_wr(3'd2, 8'h00);
      tick_pattern("m3e_t", 2, 8, 16'b11001100);

      gate[0] = 1'b0;
      io_wr(3'd4, 8'h30);
      io_wr(3'd0, 8'h34);
      io_wr(3'd0, 8'h12);
      wait_tick();
      io_wr(3'd4, 8'h00);
      gate[0] = 1'b1;
      repeat (5) wait_tick();
      gate[0] = 1'b0;
      io_wr(3'd4, 8'h00);
      io_rd(3'd0, d, d2);
      check("latch_lsb", d, 8'h34);
      io_rd(3'd0, d, d2);
      check("latch_msb", d, 8'h12);
      io_rd(3'd0, d, d2);
      check("live_lsb", d, 8'h2F);
      io_rd(3'd0, d, d2);
      check("live_msb", d, 8'h12);

      io_wr(3'd4, 8'h00);
      io_rd2(3'd0, d);
      check("rd2_lsb", d, 8'h2F);
      io_rd(3'd0, d, d2);
      check("rd2_then_msb", d, 8'h12);
      io_rd(3'd0, d, d2);
      check("rd2_latch_done", d, 8'h2F);

      io_wr(3'd6, 8'h30);
      io_wr(3'd2, 8'h07);
      io_rd(3'd2, d, d2);
      check("nch2_data_rd", d2, 0);
      io_rd(3'd6, d, d2);
      check("nch2_ctrl_rd", d2, 0);
      io_rd(3'd0, d, d2);
      check("nch2_ch0_rd", d2, 8'h12);

      clock_rate = 28'(TICK_HZ);
      repeat (3) @(posedge clk);
      tick_cnt = 0;
      repeat (200) begin
         @(posedge clk); #1;
         if (dut.tick) tick_cnt++;
      end
      check("no_tick_rate_eq", tick_cnt, 0);

      clock_rate = '0;
      repeat (3) @(posedge clk);
      tick_cnt = 0;
      repeat (1000) begin
         @(posedge clk); #1;
         if (dut.tick) tick_cnt++;
      end
      check("no_tick_rate0", tick_cnt, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pit_multi.md
Name: pit_multi

Overview:
Parametrised successor to the PC-compatible interval timer: NUM_CH independent down-counters of CNT_W bits with a per-channel control port. Counters share one fractional-rate tick generator derived from the runtime clock_rate. Supports modes 0, 2 and 3, count latch, and LSB/MSB access sequencing. Each channel provides an out level plus a one-cycle rising-edge pulse. Sits on the soc io bus beside the legacy timer, for extra system/audio timers.

Parameters:
NUM_CH, 3, number of channels, 1..4
CNT_W, 16, counter width, 9..16; count value 0 means 2^CNT_W
TICK_HZ, 1193182, tick rate in Hz, added to the accumulator every clk
RATE_W, 28, width of clock_rate and of the accumulator

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
clock_rate  in  RATE_W  clk frequency in Hz, registered internally
io_address  in  3  0..3 = data port of channel n; 4..7 = control port of channel (addr-4)
io_read  in  1  read strobe
io_readdata  out  8  registered read data
io_write  in  1  write strobe, single cycle
io_writedata  in  8  write data
gate  in  NUM_CH  per-channel gate level
out  out  NUM_CH  per-channel output level
out_rise  out  NUM_CH  one-cycle pulse on each 0->1 transition of out[n]

Behaviour:
- Clock/reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: io_readdata=0, out=all ones, out_rise=0, accumulator=0. Each channel resets to: mode 0, access 11, unprogrammed (no counting), latch empty, byte flip-flops at LSB.
- Reset mid-operation aborts all counting and sequencing immediately.
- Tick generation, every clk:
  - acc += TICK_HZ; if acc >= clock_rate_reg then acc -= clock_rate_reg and tick=1.
  - clock_rate_reg == 0 or clock_rate_reg <= TICK_HZ: tick is never asserted.
- Read qualification: a read is valid when io_read=1 and the previous cycle was not a valid read, so a 2-cycle strobe counts once. io_readdata is registered and updates the cycle after the read. Invalid or out-of-range reads return 0.
- Addresses with index >= NUM_CH: writes are ignored, reads return 0.
- Control word fields: [5:4] access, [3:1] mode, [0] ignored; bits [7:6] ignored.
  - access 00: latch current count. Ignored if a latch is already pending.
  - access 01 = LSB only, 10 = MSB only, 11 = LSB then MSB.
  - Mode 0/2/3 taken as-is. Mode 6 maps to 2, mode 7 maps to 3, modes 1/4/5 map to 0.
  - Effect of a non-latch control write: channel becomes unprogrammed, write and read flip-flops reset to LSB, pending latch cleared. out=0 in mode 0, out=1 in modes 2/3.
- Count write:
  - Access 11 needs both bytes; the load completes on the MSB write.
  - Unwritten byte of an 8-bit access is 0; in MSB-only mode the value is MSB<<8.
  - Pending count is transferred on the next tick.
  - Mode 0 sets out=0 when the write completes, even if the channel is already running.
- Mode 0: on each tick with gate=1, count -= 1 (wraps 0 -> max). out goes 1 on the tick the count reaches 0 and stays 1 until the next control or count write.
- Mode 2: with gate=1, count decrements. On the tick count reaches 1, out=0; on the next tick out=1 and the count reloads. Gate low forces out=1 and holds the count; the next tick with gate high reloads.
- Mode 3:
  - Reload value R = N with bit 0 cleared; decrement by 2 per tick. When the count reaches 0, out toggles and the counter reloads.
  - Odd N: the high phase inserts one extra hold tick after reload.
  - N=2 gives one tick high, one tick low. N=1 is treated as N=2^CNT_W.
  - Gate low forces out=1 and holds; gate high reloads on the next tick.
- Data read:
  - Returns the latched value if a latch is pending, otherwise the live count, byte selected per access mode.
  - Access 11 alternates LSB then MSB. The latch clears once all bytes of its access mode have been read.
- Simultaneous events:
  - Control write on a tick cycle: the control write wins, no count change.
  - Latch on a tick cycle: captures the pre-tick count.
- out_rise[n] = out[n] & ~out_q[n]. It does not fire at reset release.

Decomposition:
- Package pit_multi_pkg: mode encoding constants (MODE_0/2/3), access constants (ACC_LATCH/LSB/MSB/WORD), mode-mapping function.
- Sub-module pit_multi_channel: one channel's control, count, latch and mode FSM; input tick, gate, decoded write/read/control strobes. Instantiate it NUM_CH times with a generate loop.
- Top level holds the tick accumulator, address decode, read mux and io_readdata register.

Test Plan:
- clock_rate=TICK_HZ*4: tick every 4th clk, steady, with no tick for 4 clk after reset release. clock_rate=0: no tick over 1000 clk.
- Ch0 mode 0, access 11, write 0x05 then 0x00: out=0 at write; out=1 exactly 6 ticks after the MSB write (1 load + 5 decrements); still 1 after 10 more ticks; out_rise pulses once.
- Ch1 mode 2, N=4, gate=1: out low for 1 tick every 4 ticks. gate=0 mid-count: out=1 and count held; gate=1: reload, then low 4 ticks later.
- Ch2 mode 3, N=5: out high 3 ticks, low 2 ticks, repeating. N=4: 2 high / 2 low.
- Latch: ch0 running at 0x1234, control access 00, wait 5 ticks; reads return 0x34 then 0x12. A third read returns the live LSB. A second latch issued before the reads leaves the latched value unchanged.
- NUM_CH=2: write/read on address 2 and control address 6 have no effect and return 0. A 2-cycle io_read strobe advances the LSB/MSB flip-flop only once.
